lc3_mem_ctrl: RTL and testbench

- Memory and memory-mapped I/O stage that sits directly behind the LC_3 datapath. It answers the datapath's MAR/MDR accesses with an LC-3 style ready handshake (R) after a configurable wait-state count.
- Holds the main word-addressed RAM plus the keyboard and display device registers (KBSR/KBDR/DSR/DDR).
- LC_3 instantiates it internally; the top-level bench still drives only `clock`.

---
 rtl/lc3_mem_pkg.sv | 20 ++
 rtl/lc3_io_regs.sv | 86 ++++++++
 rtl/lc3_mem_ctrl.sv | 152 +++++++++++++++
 tb/tb_lc3_mem_ctrl.sv | 284 ++++++++++++++++++++++++++++
 4 files changed

// File: rtl/lc3_mem_pkg.sv
// Shared definitions for the LC-3 memory / memory-mapped I/O stage.
//   ADDR_KBSR..ADDR_DDR : device register addresses (full 16-bit match)
//   DSR_RESET           : display status after reset (display ready)
//   mem_state_t         : access FSM states
package lc3_mem_pkg;

    localparam logic [15:0] ADDR_KBSR = 16'hFE00;
    localparam logic [15:0] ADDR_KBDR = 16'hFE02;
    localparam logic [15:0] ADDR_DSR  = 16'hFE04;
    localparam logic [15:0] ADDR_DDR  = 16'hFE06;

    localparam logic [15:0] DSR_RESET = 16'h8000;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        WAIT = 2'd1,
        DONE = 2'd2
    } mem_state_t;

endpackage

// File: rtl/lc3_io_regs.sv
// Keyboard and display device registers with their handshakes.
//   clock, reset_n        : clock, async active-low reset
//   sel[3:0]              : one-hot register select {DDR, DSR, KBDR, KBSR}
//   we, re                : write / read strobes, asserted for the commit cycle
//   wdata[7:0]            : write data (only DDR takes data)
//   rdata[15:0]           : read data for the selected register
//   kbd_valid/kbd_data    : incoming keyboard character
//   kbd_ready             : keyboard register empty
//   disp_valid/disp_data  : pending display character
//   disp_ack              : display consumed the character
module lc3_io_regs
    import lc3_mem_pkg::*;
(
    input  logic        clock,
    input  logic        reset_n,
    input  logic [3:0]  sel,
    input  logic        we,
    input  logic        re,
    input  logic [7:0]  wdata,
    output logic [15:0] rdata,
    input  logic        kbd_valid,
    input  logic [7:0]  kbd_data,
    output logic        kbd_ready,
    output logic        disp_valid,
    output logic [7:0]  disp_data,
    input  logic        disp_ack
);

    // Only the architecturally visible bits are stored.
    logic       kbsr_full;
    logic [7:0] kbdr_q;
    logic       dsr_rdy;
    logic [7:0] ddr_q;
    logic       disp_pend;

    logic kbdr_rd;
    logic ddr_wr;
    logic kbd_take;

    assign kbdr_rd  = re & sel[1];
    assign ddr_wr   = we & sel[3];
    // A KBDR read in the same cycle blocks acceptance: the clear wins.
    assign kbd_take = kbd_valid & ~kbsr_full & ~kbdr_rd;

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            kbsr_full <= 1'b0;
            kbdr_q    <= 8'h00;
            dsr_rdy   <= DSR_RESET[15];
            ddr_q     <= 8'h00;
            disp_pend <= 1'b0;
        end else begin
            if (kbdr_rd) begin
                kbsr_full <= 1'b0;
            end else if (kbd_take) begin
                kbsr_full <= 1'b1;
                kbdr_q    <= kbd_data;
            end

            // A DDR write beats a simultaneous acknowledge.
            if (ddr_wr) begin
                ddr_q     <= wdata;
                dsr_rdy   <= 1'b0;
                disp_pend <= 1'b1;
            end else if (disp_ack && disp_pend) begin
                dsr_rdy   <= 1'b1;
                disp_pend <= 1'b0;
            end
        end
    end

    always_comb begin
        rdata = 16'h0000;
        unique case (1'b1)
            sel[0]:  rdata = {kbsr_full, 15'b0};
            sel[1]:  rdata = {8'h00, kbdr_q};
            sel[2]:  rdata = {dsr_rdy, 15'b0};
            default: rdata = 16'h0000;
        endcase
    end

    assign kbd_ready  = ~kbsr_full;
    assign disp_valid = disp_pend;
    assign disp_data  = ddr_q;

endmodule

// File: rtl/lc3_mem_ctrl.sv
// LC-3 memory stage: word RAM plus memory-mapped keyboard/display, answering
// MAR/MDR accesses with a one-cycle ready strobe after LATENCY wait cycles.
//   clock, reset_n        : clock, async active-low reset
//   mem_en, r_w           : access request (held until r), 1 = write
//   mar, mdr_in           : access address and write data
//   mdr_out, r            : read data and completion strobe
//   kbd_*, disp_*         : device handshakes, see lc3_io_regs
//
// state | meaning
// IDLE  | waiting for mem_en, captures the request
// WAIT  | counting LATENCY wait cycles
// DONE  | r = 1 for one cycle, result on mdr_out
module lc3_mem_ctrl
    import lc3_mem_pkg::*;
#(
    parameter int    ADDR_W    = 16,
    parameter int    LATENCY   = 2,
    parameter string INIT_FILE = ""
) (
    input  logic        clock,
    input  logic        reset_n,
    input  logic        mem_en,
    input  logic        r_w,
    input  logic [15:0] mar,
    input  logic [15:0] mdr_in,
    output logic [15:0] mdr_out,
    output logic        r,
    input  logic        kbd_valid,
    input  logic [7:0]  kbd_data,
    output logic        kbd_ready,
    output logic        disp_valid,
    output logic [7:0]  disp_data,
    input  logic        disp_ack
);

    localparam logic [3:0] LAT_LAST = (LATENCY > 0) ? 4'(LATENCY - 1) : 4'd0;

    mem_state_t  state, state_nxt;
    logic [3:0]  cnt;
    logic [15:0] cap_addr;
    logic [15:0] cap_data;
    logic        cap_rw;
    logic        commit;

    logic [15:0] eff_addr;
    logic [15:0] eff_data;
    logic        eff_rw;
    logic [3:0]  io_sel;
    logic        is_dev;
    logic [15:0] io_rdata;

    logic [15:0] ram [0:(1 << ADDR_W) - 1];

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) state <= IDLE;
        else          state <= state_nxt;
    end

    always_comb begin
        state_nxt = state;
        commit    = 1'b0;
        r         = 1'b0;
        unique case (state)
            IDLE: begin
                if (mem_en) begin
                    if (LATENCY == 0) begin
                        state_nxt = DONE;
                        commit    = 1'b1;
                    end else begin
                        state_nxt = WAIT;
                    end
                end
            end
            WAIT: begin
                if (cnt == LAT_LAST) begin
                    state_nxt = DONE;
                    commit    = 1'b1;
                end
            end
            DONE: begin
                r         = 1'b1;
                state_nxt = IDLE;
            end
            default: state_nxt = IDLE;
        endcase
    end

    // With zero latency the commit coincides with capture, so the live
    // request is used; otherwise the captured copy.
    assign eff_addr = (state == IDLE) ? mar    : cap_addr;
    assign eff_data = (state == IDLE) ? mdr_in : cap_data;
    assign eff_rw   = (state == IDLE) ? r_w    : cap_rw;

    always_comb begin
        io_sel = 4'b0000;
        case (eff_addr)
            ADDR_KBSR: io_sel = 4'b0001;
            ADDR_KBDR: io_sel = 4'b0010;
            ADDR_DSR:  io_sel = 4'b0100;
            ADDR_DDR:  io_sel = 4'b1000;
            default:   io_sel = 4'b0000;
        endcase
    end

    assign is_dev = |io_sel;

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            cnt      <= 4'd0;
            cap_addr <= 16'h0000;
            cap_data <= 16'h0000;
            cap_rw   <= 1'b0;
            mdr_out  <= 16'h0000;
        end else begin
            if (state == IDLE && mem_en) begin
                cnt      <= 4'd0;
                cap_addr <= mar;
                cap_data <= mdr_in;
                cap_rw   <= r_w;
            end else if (state == WAIT) begin
                cnt <= cnt + 4'd1;
            end

            if (commit && !eff_rw) begin
                mdr_out <= is_dev ? io_rdata : ram[eff_addr[ADDR_W-1:0]];
            end
        end
    end

    always_ff @(posedge clock) begin
        if (commit && eff_rw && !is_dev) begin
            ram[eff_addr[ADDR_W-1:0]] <= eff_data;
        end
    end

    lc3_io_regs u_io (
        .clock      (clock),
        .reset_n    (reset_n),
        .sel        (io_sel),
        .we         (commit & eff_rw),
        .re         (commit & ~eff_rw),
        .wdata      (eff_data[7:0]),
        .rdata      (io_rdata),
        .kbd_valid  (kbd_valid),
        .kbd_data   (kbd_data),
        .kbd_ready  (kbd_ready),
        .disp_valid (disp_valid),
        .disp_data  (disp_data),
        .disp_ack   (disp_ack)
    );

endmodule

// File: tb/tb_lc3_mem_ctrl.sv
// Self-checking bench for lc3_mem_ctrl: instance 0 has LATENCY = 2, instance 1
// LATENCY = 0; both use a 12-bit RAM so device addresses alias RAM words.
module tb_lc3_mem_ctrl;

    logic        clock;
    logic        rst_n      [2];
    logic        mem_en     [2];
    logic        r_w        [2];
    logic [15:0] mar        [2];
    logic [15:0] mdr_in     [2];
    logic [15:0] mdr_out    [2];
    logic        r          [2];
    logic        kbd_valid  [2];
    logic [7:0]  kbd_data   [2];
    logic        kbd_ready  [2];
    logic        disp_valid [2];
    logic [7:0]  disp_data  [2];
    logic        disp_ack   [2];

    int lat_of [2] = '{2, 0};

    int n_checks = 0;
    int n_fail   = 0;

    // Reference model: device state in terms of what the software sees.
    bit          kb_full   [2];
    logic [7:0]  kb_char   [2];
    bit          disp_full [2];
    logic [7:0]  disp_char [2];
    logic [15:0] ram_m [int];

    lc3_mem_ctrl #(.ADDR_W(12), .LATENCY(2)) u_dut (
        .clock(clock), .reset_n(rst_n[0]), .mem_en(mem_en[0]), .r_w(r_w[0]),
        .mar(mar[0]), .mdr_in(mdr_in[0]), .mdr_out(mdr_out[0]), .r(r[0]),
        .kbd_valid(kbd_valid[0]), .kbd_data(kbd_data[0]), .kbd_ready(kbd_ready[0]),
        .disp_valid(disp_valid[0]), .disp_data(disp_data[0]), .disp_ack(disp_ack[0])
    );

    lc3_mem_ctrl #(.ADDR_W(12), .LATENCY(0)) u_dut0 (
        .clock(clock), .reset_n(rst_n[1]), .mem_en(mem_en[1]), .r_w(r_w[1]),
        .mar(mar[1]), .mdr_in(mdr_in[1]), .mdr_out(mdr_out[1]), .r(r[1]),
        .kbd_valid(kbd_valid[1]), .kbd_data(kbd_data[1]), .kbd_ready(kbd_ready[1]),
        .disp_valid(disp_valid[1]), .disp_data(disp_data[1]), .disp_ack(disp_ack[1])
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

    task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got=%0h expected=%0h", tag, got, exp);
        end
    endtask

    task automatic mdl_reset(input int i);
        kb_full[i]   = 1'b0;
        kb_char[i]   = 8'h00;
        disp_full[i] = 1'b0;
        disp_char[i] = 8'h00;
    endtask

    // Applies one access to the model and returns the value a read must see.
    task automatic mdl_access(input int i, input bit wr, input logic [15:0] a,
                              input logic [15:0] d, output logic [15:0] exp,
                              output bit known);
        int key;
        key   = i * 65536 + int'(a & 16'h0FFF);
        exp   = 16'h0000;
        known = 1'b1;
        case (a)
            16'hFE00: exp = {kb_full[i], 15'b0};
            16'hFE02: begin
                exp = {8'h00, kb_char[i]};
                if (!wr) kb_full[i] = 1'b0;
            end
            16'hFE04: exp = {~disp_full[i], 15'b0};
            16'hFE06: begin
                exp = 16'h0000;
                if (wr) begin
                    disp_full[i] = 1'b1;
                    disp_char[i] = d[7:0];
                end
            end
            default: begin
                if (wr) ram_m[key] = d;
                else if (ram_m.exists(key)) exp = ram_m[key];
                else known = 1'b0;
            end
        endcase
    endtask

    task automatic status(input int i);
        check_val("kbd_ready", kbd_ready[i], !kb_full[i]);
        check_val("disp_valid", disp_valid[i], disp_full[i]);
        check_val("disp_data", disp_data[i], disp_char[i]);
    endtask

    // Starts and finishes at a negedge. Request inputs are scrambled after
    // capture; optionally disp_ack is raised for the commit edge only.
    task automatic do_access(input int i, input string tag, input bit wr,
                             input logic [15:0] a, input logic [15:0] d,
                             input bit ack_at_commit);
        logic [15:0] exp;
        bit          known;
        int          cnt;
        bit          seen;
        logic [15:0] got;
        mem_en[i] = 1'b1;
        r_w[i]    = wr;
        mar[i]    = a;
        mdr_in[i] = d;
        cnt  = 0;
        seen = 1'b0;
        got  = 16'h0000;
        while (!seen && cnt < 40) begin
            if (ack_at_commit && cnt == lat_of[i]) disp_ack[i] = 1'b1;
            @(posedge clock);
            cnt++;
            @(negedge clock);
            if (r[i]) begin
                seen = 1'b1;
                got  = mdr_out[i];
            end else if (cnt == 1) begin
                mar[i]    = 16'($urandom);
                mdr_in[i] = 16'($urandom);
                r_w[i]    = 1'($urandom);
            end
        end
        mem_en[i]    = 1'b0;
        kbd_valid[i] = 1'b0;
        disp_ack[i]  = 1'b0;
        mdl_access(i, wr, a, d, exp, known);
        check_val({tag, "_r_seen"}, seen, 1);
        check_val({tag, "_latency"}, cnt, lat_of[i] + 1);
        if (!wr && known) check_val({tag, "_data"}, got, exp);
        @(posedge clock);
        @(negedge clock);
        check_val({tag, "_r_one_cycle"}, r[i], 0);
    endtask

    task automatic kbd_push(input int i, input logic [7:0] c);
        kbd_valid[i] = 1'b1;
        kbd_data[i]  = c;
        @(posedge clock);
        @(negedge clock);
        kbd_valid[i] = 1'b0;
        if (!kb_full[i]) begin
            kb_full[i] = 1'b1;
            kb_char[i] = c;
        end
    endtask

    task automatic disp_consume(input int i);
        disp_ack[i] = 1'b1;
        @(posedge clock);
        @(negedge clock);
        disp_ack[i] = 1'b0;
        disp_full[i] = 1'b0;
    endtask

    function automatic logic [15:0] rand_addr();
        logic [15:0] dev [5];
        dev = '{16'hFE00, 16'hFE02, 16'hFE04, 16'hFE06, 16'hFE01};
        if ($urandom_range(0, 9) < 3) return dev[$urandom_range(0, 4)];
        return 16'($urandom) & 16'hF00F;
    endfunction

    initial begin
        for (int i = 0; i < 2; i++) begin
            rst_n[i] = 1'b0; mem_en[i] = 1'b0; r_w[i] = 1'b0;
            mar[i] = 16'h0; mdr_in[i] = 16'h0; kbd_valid[i] = 1'b0;
            kbd_data[i] = 8'h0; disp_ack[i] = 1'b0;
            mdl_reset(i);
        end
        repeat (3) @(negedge clock);
        rst_n[0] = 1'b1;
        rst_n[1] = 1'b1;
        @(negedge clock);

        for (int i = 0; i < 2; i++) begin
            check_val("rst_r", r[i], 0);
            check_val("rst_mdr_out", mdr_out[i], 16'h0000);
            status(i);
        end

        // Write then read back.
        do_access(0, "wr3000", 1, 16'h3000, 16'h1234, 0);
        do_access(0, "rd3000", 0, 16'h3000, 16'h0000, 0);

        // Keyboard: second character offered across the KBDR read is refused.
        kbd_push(0, 8'h41);
        status(0);
        do_access(0, "rd_kbsr_full", 0, 16'hFE00, 16'h0, 0);
        kbd_valid[0] = 1'b1;
        kbd_data[0]  = 8'h42;
        do_access(0, "rd_kbdr", 0, 16'hFE02, 16'h0, 0);
        status(0);
        do_access(0, "rd_kbsr_empty", 0, 16'hFE00, 16'h0, 0);
        do_access(0, "rd_kbdr_again", 0, 16'hFE02, 16'h0, 0);

        // Display.
        do_access(0, "rd_dsr_rdy", 0, 16'hFE04, 16'h0, 0);
        do_access(0, "wr_ddr", 1, 16'hFE06, 16'h0048, 0);
        status(0);
        do_access(0, "rd_dsr_busy", 0, 16'hFE04, 16'h0, 0);
        do_access(0, "rd_ddr", 0, 16'hFE06, 16'h0, 0);
        disp_consume(0);
        status(0);
        do_access(0, "rd_dsr_acked", 0, 16'hFE04, 16'h0, 0);
        do_access(0, "wr_ddr_a", 1, 16'hFE06, 16'h0055, 0);
        do_access(0, "wr_ddr_ovr", 1, 16'hFE06, 16'h0066, 1);
        status(0);
        do_access(0, "rd_dsr_collide", 0, 16'hFE04, 16'h0, 0);
        disp_consume(0);
        status(0);

        // Device-address writes must not reach the aliased RAM word.
        do_access(0, "wr_e00", 1, 16'h0E00, 16'h7777, 0);
        do_access(0, "wr_kbsr", 1, 16'hFE00, 16'hFFFF, 0);
        do_access(0, "wr_kbdr", 1, 16'hFE02, 16'hFFFF, 0);
        do_access(0, "rd_kbsr_iso", 0, 16'hFE00, 16'h0, 0);
        do_access(0, "rd_e00_iso", 0, 16'h0E00, 16'h0, 0);
        status(0);

        // Reset in the middle of a write.
        do_access(0, "wr4000", 1, 16'h4000, 16'h1111, 0);
        mem_en[0] = 1'b1; r_w[0] = 1'b1; mar[0] = 16'h4000; mdr_in[0] = 16'hBEEF;
        @(posedge clock);
        @(negedge clock);
        rst_n[0]  = 1'b0;
        mem_en[0] = 1'b0;
        mdl_reset(0);
        for (int k = 0; k < 3; k++) begin
            @(negedge clock);
            check_val("rst_mid_r_low", r[0], 0);
        end
        rst_n[0] = 1'b1;
        for (int k = 0; k < 4; k++) begin
            @(negedge clock);
            check_val("post_rst_r_low", r[0], 0);
        end
        status(0);
        do_access(0, "rd4000_after_rst", 0, 16'h4000, 16'h0, 0);

        // Zero latency, back-to-back reads with mem_en held.
        do_access(1, "l0_wr0", 1, 16'h0000, 16'hAAAA, 0);
        do_access(1, "l0_wr1", 1, 16'h0001, 16'h5555, 0);
        mem_en[1] = 1'b1; r_w[1] = 1'b0; mar[1] = 16'h0000;
        @(posedge clock);
        @(negedge clock);
        check_val("b2b_r0", r[1], 1);
        check_val("b2b_d0", mdr_out[1], 16'hAAAA);
        mar[1] = 16'h0001;
        @(posedge clock);
        @(negedge clock);
        check_val("b2b_gap", r[1], 0);
        @(posedge clock);
        @(negedge clock);
        check_val("b2b_r1", r[1], 1);
        check_val("b2b_d1", mdr_out[1], 16'h5555);
        mem_en[1] = 1'b0;
        @(posedge clock);
        @(negedge clock);
        check_val("b2b_end", r[1], 0);

        // Randomized traffic on both instances.
        for (int n = 0; n < 300; n++) begin
            int i;
            int op;
            i  = (n % 3 == 0) ? 1 : 0;
            op = $urandom_range(0, 7);
            if (op < 6) do_access(i, "rand", 1'($urandom), rand_addr(), 16'($urandom), 0);
            else if (op == 6) kbd_push(i, 8'($urandom));
            else disp_consume(i);
            status(i);
        end

        $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
        $finish;
    end

endmodule
